press_classifier_amisha: RTL and testbench

- Consumes the debounced level and rising-edge tick produced by the switch debouncer.
- Classifies each press as short, long or double, and emits one-cycle event pulses plus a running press count.
- Sits between the debouncer and the application logic (LED/counter display) in the same clock domain.
- All timing is expressed in clock cycles.

---
 rtl/press_classifier_amisha.sv | 141 ++++++++++++++
 tb/tb_press_classifier_amisha.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier_amisha.sv
// Press classifier: turns a debounced switch level/tick into short, long and
// double press event pulses, plus a wrapping count of press starts.
module press_classifier_amisha #(
  parameter int unsigned LONG_CYCLES    = 50000000,
  parameter int unsigned DBL_GAP_CYCLES = 15000000,
  parameter int unsigned TMR_W          = 26,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             db_level_amisha,
  input  logic             db_tick_amisha,
  output logic             short_tick_amisha,
  output logic             long_tick_amisha,
  output logic             double_tick_amisha,
  output logic [CNT_W-1:0] press_count_amisha,
  output logic             busy_amisha
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESSED   = 3'd1;
  localparam logic [2:0] S_LONG_HELD = 3'd2;
  localparam logic [2:0] S_WAIT_2ND  = 3'd3;
  localparam logic [2:0] S_PRESSED_2 = 3'd4;

  localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(DBL_GAP_CYCLES - 1);

  logic [2:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_lvl_q;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic [2:0]       w_state_d;
  logic [TMR_W-1:0] w_timer_d;
  logic             w_short_d;
  logic             w_long_d;
  logic             w_double_d;
  logic             w_rel;
  logic [CNT_W-1:0] w_count_d;

  assign w_rel     = r_lvl_q & ~db_level_amisha;
  assign w_count_d = r_count + {{(CNT_W-1){1'b0}}, db_tick_amisha};

  // Release takes priority over the long timeout, and a new press over the
  // gap timeout, so both checks come first in their states.
  always_comb begin
    w_state_d  = r_state;
    w_timer_d  = r_timer;
    w_short_d  = 1'b0;
    w_long_d   = 1'b0;
    w_double_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (db_tick_amisha) begin
          w_state_d = S_PRESSED;
          w_timer_d = '0;
        end
      end
      S_PRESSED: begin
        if (w_rel) begin
          w_state_d = S_WAIT_2ND;
          w_timer_d = '0;
        end else if (r_timer == LONG_LAST) begin
          w_state_d = S_LONG_HELD;
          w_timer_d = '0;
          w_long_d  = 1'b1;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (w_rel) begin
          w_state_d = S_IDLE;
        end
      end
      S_WAIT_2ND: begin
        if (db_tick_amisha) begin
          w_state_d = S_PRESSED_2;
          w_timer_d = '0;
        end else if (r_timer == GAP_LAST) begin
          w_state_d = S_IDLE;
          w_timer_d = '0;
          w_short_d = 1'b1;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      S_PRESSED_2: begin
        if (w_rel) begin
          w_state_d  = S_IDLE;
          w_timer_d  = '0;
          w_double_d = 1'b1;
        end else if (r_timer == LONG_LAST) begin
          w_state_d = S_LONG_HELD;
          w_timer_d = '0;
          w_long_d  = 1'b1;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_d = S_IDLE;
        w_timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_lvl_q  <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_d;
      r_timer  <= w_timer_d;
      r_lvl_q  <= db_level_amisha;
      r_short  <= w_short_d;
      r_long   <= w_long_d;
      r_double <= w_double_d;
      r_busy   <= (w_state_d != S_IDLE);
      r_count  <= w_count_d;
    end
  end

  assign short_tick_amisha  = r_short;
  assign long_tick_amisha   = r_long;
  assign double_tick_amisha = r_double;
  assign busy_amisha        = r_busy;
  assign press_count_amisha = r_count;

endmodule

// File: tb/tb_press_classifier_amisha.sv
// Bench for press_classifier_amisha: press sequences described as hold/gap
// lengths, with expected events derived arithmetically from those lengths.
module tb_press_classifier_amisha;

  localparam int L    = 20;
  localparam int D    = 10;
  localparam int CW   = 8;
  localparam int MAXC = 8192;
  localparam int MAXP = 300;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          lvl   = 1'b0;
  logic          tick  = 1'b0;
  logic          short_t;
  logic          long_t;
  logic          dbl_t;
  logic          busy;
  logic [CW-1:0] cnt;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            seq_h[MAXP];
  int            seq_g[MAXP];
  logic [2:0]    exp_ev[MAXC];
  logic          exp_busy[MAXC];
  logic [CW-1:0] exp_cnt = '0;

  press_classifier_amisha #(
    .LONG_CYCLES   (L),
    .DBL_GAP_CYCLES(D),
    .TMR_W         (26),
    .CNT_W         (CW)
  ) dut (
    .clk_amisha        (clk),
    .reset_amisha      (rst_n),
    .db_level_amisha   (lvl),
    .db_tick_amisha    (tick),
    .short_tick_amisha (short_t),
    .long_tick_amisha  (long_t),
    .double_tick_amisha(dbl_t),
    .press_count_amisha(cnt),
    .busy_amisha       (busy)
  );

  always #50 clk = ~clk;

  task automatic mark_busy(input int a, input int b);
    for (int c = a; c < b; c++) exp_busy[c] = 1'b1;
  endtask

  // Expected behaviour, in edge indices relative to the start of the run:
  // press i starts at st[i], releases at st[i]+h; the event pulse becomes
  // visible right after the deciding edge. ev bits are {short, long, double}.
  task automatic run_seq(input int np, input string name);
    int st[MAXP];
    int t, total, pend_rel, bstart, ti, ri, p;
    bit pend;
    if (seq_g[np-1] < D + 3) seq_g[np-1] = D + 3;
    t = 0;
    for (int i = 0; i < np; i++) begin
      st[i] = t;
      t += seq_h[i] + seq_g[i];
    end
    total = t;
    for (int c = 0; c < total; c++) begin
      exp_ev[c]   = 3'b000;
      exp_busy[c] = 1'b0;
    end
    pend = 0; pend_rel = 0; bstart = 0;
    for (int i = 0; i < np; i++) begin
      ti = st[i];
      ri = ti + seq_h[i];
      if (pend && (ti - pend_rel) > D) begin
        exp_ev[pend_rel + D] = 3'b100;
        mark_busy(bstart, pend_rel + D);
        pend = 0;
      end
      if (!pend) begin
        bstart = ti;
        if (seq_h[i] > L) begin
          exp_ev[ti + L] = 3'b010;
          mark_busy(ti, ri);
        end else begin
          pend     = 1;
          pend_rel = ri;
        end
      end else begin
        pend = 0;
        if (seq_h[i] > L) exp_ev[ti + L] = 3'b010;
        else              exp_ev[ri]     = 3'b001;
        mark_busy(bstart, ri);
      end
    end
    if (pend) begin
      exp_ev[pend_rel + D] = 3'b100;
      mark_busy(bstart, pend_rel + D);
    end

    p = 0;
    for (int c = 0; c < total; c++) begin
      tick = (p < np) && (c == st[p]);
      lvl  = (p < np) && (c >= st[p]) && (c < st[p] + seq_h[p]);
      if (tick) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({short_t, long_t, dbl_t, busy, cnt} !== {exp_ev[c], exp_busy[c], exp_cnt}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got ev=%b busy=%b cnt=%0d, want ev=%b busy=%b cnt=%0d",
                 name, c, {short_t, long_t, dbl_t}, busy, cnt, exp_ev[c], exp_busy[c],
                 exp_cnt);
      end
      if (p < np && c == st[p] + seq_h[p] + seq_g[p] - 1) p++;
    end
    tick = 1'b0;
    lvl  = 1'b0;
  endtask

  task automatic idle_check(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({short_t, long_t, dbl_t, busy, cnt} !== {4'b0000, exp_cnt}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got ev=%b busy=%b cnt=%0d, want all idle cnt=%0d",
                 name, c, {short_t, long_t, dbl_t}, busy, cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    lvl   = 1'b1;
    tick  = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({short_t, long_t, dbl_t, busy, cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got ev=%b busy=%b cnt=%0d, want all zero",
               {short_t, long_t, dbl_t}, busy, cnt);
    end
    lvl     = 1'b0;
    tick    = 1'b0;
    exp_cnt = '0;
    rst_n   = 1'b1;
    idle_check(5, "reset_release");
  endtask

  task automatic test_short;
    seq_h[0] = 5; seq_g[0] = D + 4;
    run_seq(1, "short");
  endtask

  task automatic test_long;
    seq_h[0] = 30; seq_g[0] = D + 4;
    run_seq(1, "long");
  endtask

  task automatic test_long_boundary;
    seq_h[0] = L;     seq_g[0] = D + 3;
    seq_h[1] = L + 1; seq_g[1] = 2;
    seq_h[2] = 4;     seq_g[2] = 3;
    seq_h[3] = L;     seq_g[3] = D + 3;
    run_seq(4, "long_boundary");
  endtask

  task automatic test_double;
    seq_h[0] = 4; seq_g[0] = 5;
    seq_h[1] = 4; seq_g[1] = D + 4;
    run_seq(2, "double");
  endtask

  task automatic test_double_long;
    seq_h[0] = 4; seq_g[0] = 3;
    seq_h[1] = 25; seq_g[1] = D + 4;
    run_seq(2, "double_long");
  endtask

  task automatic test_gap_boundary;
    seq_h[0] = 4; seq_g[0] = D;
    seq_h[1] = 4; seq_g[1] = D + 3;
    run_seq(2, "gap_equal");
    seq_h[0] = 4; seq_g[0] = D + 1;
    seq_h[1] = 4; seq_g[1] = D + 3;
    run_seq(2, "gap_over");
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 12; i++) begin
        seq_h[i] = int'($urandom_range(1, 25));
        seq_g[i] = int'($urandom_range(1, 14));
      end
      run_seq(12, "random");
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    tick = 1'b1;
    lvl  = 1'b1;
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    lvl = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait_busy: got busy=%b, want 1", busy);
    end
    #20 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({short_t, long_t, dbl_t, busy, cnt} !== '0) begin
      n_fail++;
      $display("FAIL mid_wait_async: got ev=%b busy=%b cnt=%0d, want all zero",
               {short_t, long_t, dbl_t}, busy, cnt);
    end
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check(D + 5, "mid_wait_after");
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 256; i++) begin
      seq_h[i] = 1 + (i % 3);
      seq_g[i] = D + 2;
    end
    run_seq(256, "wrap");
    n_tests++;
    if (cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_final: got cnt=%0d, want 0", cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_short();
    test_long();
    test_long_boundary();
    test_double();
    test_double_long();
    test_gap_boundary();
    test_random();
    test_reset_mid_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
